// File: rtl/sequence_generator_moore_tx.sv
// rtl/sequence_generator_moore_tx.sv - MSB-first serial pattern transmitter feeding the Moore sequence detector (optional gap insertion: SEQGEN_GAP_INSERT_EN)
module sequence_generator_moore_tx #(
    parameter int unsigned       PAT_W    = 4,
    parameter logic [PAT_W-1:0]  PATTERN  = 4'b0101,
    parameter int unsigned       CNT_W    = 4,
    parameter int unsigned       GAP_LEN  = 2,
    parameter logic              IDLE_BIT = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_frames,
    input  logic              i_pat_wr,
    input  logic [PAT_W-1:0]  i_pat_in,
    input  logic              i_stop,
    output logic              o_out,
    output logic              o_out_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_frame_cnt
);

    localparam int unsigned    BC_W     = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(PAT_W - 1);

`ifdef SEQGEN_GAP_INSERT_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_LEN - 1);
    logic [3:0]         r_gap_cnt;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd3
    } state_t;

    // Gap length has no effect when frames are sent back-to-back.
    logic [3:0]         w_unused_gap_len;
    assign w_unused_gap_len = 4'(GAP_LEN);
`endif

    state_t             r_state;
    logic [PAT_W-1:0]   r_pattern;
    logic [PAT_W-1:0]   r_shift;
    logic [BC_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]   r_frames;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_stop_seen;
    logic               r_out;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    logic [PAT_W-1:0]   w_load_pat;
    logic [CNT_W-1:0]   w_frame_cnt_inc;
    logic               w_stop;

    // A pattern written in the same cycle as start is the one transmitted.
    assign w_load_pat      = i_pat_wr ? i_pat_in : r_pattern;
    assign w_frame_cnt_inc = r_frame_cnt + 1'b1;
    assign w_stop          = r_stop_seen | i_stop;

    // Single FSM: state, shift path and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_pattern   <= PATTERN;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_frames    <= '0;
            r_frame_cnt <= '0;
            r_stop_seen <= 1'b0;
            r_out       <= IDLE_BIT;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SEQGEN_GAP_INSERT_EN
            r_gap_cnt   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_out       <= IDLE_BIT;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    if (i_pat_wr) begin
                        r_pattern <= i_pat_in;
                    end
                    if (i_start && (i_frames != '0)) begin
                        r_state     <= S_SEND;
                        r_frames    <= i_frames;
                        r_frame_cnt <= '0;
                        r_stop_seen <= 1'b0;
                        r_out       <= w_load_pat[PAT_W-1];
                        r_shift     <= w_load_pat << 1;
                        r_bit_cnt   <= BIT_LAST;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (i_stop) begin
                        r_stop_seen <= 1'b1;
                    end
                    if (r_bit_cnt != '0) begin
                        r_out     <= r_shift[PAT_W-1];
                        r_shift   <= r_shift << 1;
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end else begin
                        // Bit 0 is on the line this cycle: the frame completes here.
                        r_frame_cnt <= w_frame_cnt_inc;
                        if ((w_frame_cnt_inc != r_frames) && !w_stop) begin
`ifdef SEQGEN_GAP_INSERT_EN
                            r_state     <= S_GAP;
                            r_gap_cnt   <= GAP_LAST;
                            r_out       <= IDLE_BIT;
                            r_out_valid <= 1'b0;
`else
                            r_out       <= r_pattern[PAT_W-1];
                            r_shift     <= r_pattern << 1;
                            r_bit_cnt   <= BIT_LAST;
`endif
                        end else begin
                            r_state     <= S_DONE;
                            r_out       <= IDLE_BIT;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
`ifdef SEQGEN_GAP_INSERT_EN
                S_GAP: begin
                    if (i_stop) begin
                        r_stop_seen <= 1'b1;
                    end
                    if (w_stop) begin
                        r_state     <= S_DONE;
                        r_out       <= IDLE_BIT;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (r_gap_cnt == '0) begin
                        r_state     <= S_SEND;
                        r_out       <= r_pattern[PAT_W-1];
                        r_shift     <= r_pattern << 1;
                        r_bit_cnt   <= BIT_LAST;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_sequence_generator_moore_tx.sv
// tb/tb_sequence_generator_moore_tx.sv - self-checking bench for sequence_generator_moore_tx
module tb_sequence_generator_moore_tx;

    localparam int          PAT_W    = 4;
    localparam int          CNT_W    = 4;
    localparam int          GAP_LEN  = 2;
    localparam logic [3:0]  PATTERN  = 4'b0101;
    localparam logic        IDLE_BIT = 1'b0;
`ifdef SEQGEN_GAP_INSERT_EN
    localparam int          GAPS     = GAP_LEN;
`else
    localparam int          GAPS     = 0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic [CNT_W-1:0]  i_frames;
    logic              i_pat_wr;
    logic [PAT_W-1:0]  i_pat_in;
    logic              i_stop;
    logic              o_out;
    logic              o_out_valid;
    logic              o_busy;
    logic              o_done;
    logic [CNT_W-1:0]  o_frame_cnt;

    sequence_generator_moore_tx #(
        .PAT_W    (PAT_W),
        .PATTERN  (PATTERN),
        .CNT_W    (CNT_W),
        .GAP_LEN  (GAP_LEN),
        .IDLE_BIT (IDLE_BIT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_frames    (i_frames),
        .i_pat_wr    (i_pat_wr),
        .i_pat_in    (i_pat_in),
        .i_stop      (i_stop),
        .o_out       (o_out),
        .o_out_valid (o_out_valid),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic o;
        logic v;
        logic b;
        logic d;
    } exp_t;

    exp_t              exp_q[$];
    int                exp_sent;
    logic [PAT_W-1:0]  cur_pat;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic o, input logic v, input logic b, input logic d);
        exp_t e;
        e.o = o; e.v = v; e.b = b; e.d = d;
        exp_q.push_back(e);
    endtask

    // Expected line trace, one entry per cycle from T+1 through the done cycle.
    task automatic build_model(input logic [PAT_W-1:0] pat, input int f, input int stop_at);
        int cyc;
        bit stopped;
        bit fin;
        exp_q.delete();
        cyc = 0; stopped = 0; fin = 0; exp_sent = 0;
        for (int fr = 0; fr < f && !fin; fr++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                cyc++;
                if (cyc == stop_at) stopped = 1;
                push(pat[b], 1'b1, 1'b1, 1'b0);
            end
            exp_sent++;
            if (exp_sent == f || stopped) fin = 1;
            for (int g = 0; g < GAPS && !fin; g++) begin
                cyc++;
                if (cyc == stop_at) stopped = 1;
                push(IDLE_BIT, 1'b0, 1'b1, 1'b0);
                if (stopped) fin = 1;
            end
        end
        push(IDLE_BIT, 1'b0, 1'b0, 1'b1);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the done cycle.
    task automatic run(input string name, input logic [PAT_W-1:0] pat, input int f,
                       input int stop_at, input bit use_wr, input bit poke);
        logic [PAT_W-1:0] tx_pat;
        tx_pat = use_wr ? pat : cur_pat;
        if (use_wr) cur_pat = pat;
        build_model(tx_pat, f, stop_at);
        i_start  = 1'b1;
        i_frames = CNT_W'(f);
        i_pat_wr = use_wr;
        i_pat_in = pat;
        @(negedge i_clk);
        i_start  = 1'b0;
        i_pat_wr = 1'b0;
        i_frames = CNT_W'($urandom);
        check($sformatf("%s frame_cnt_clear", name), 32'(o_frame_cnt), 32'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s out[%0d]", name, i),   32'(o_out),       32'(exp_q[i].o));
            check($sformatf("%s valid[%0d]", name, i), 32'(o_out_valid), 32'(exp_q[i].v));
            check($sformatf("%s busy[%0d]", name, i),  32'(o_busy),      32'(exp_q[i].b));
            check($sformatf("%s done[%0d]", name, i),  32'(o_done),      32'(exp_q[i].d));
            i_stop = (i + 1 == stop_at);
            if (poke && i == 1) begin
                i_start  = 1'b1;
                i_frames = CNT_W'($urandom);
                i_pat_wr = 1'b1;
                i_pat_in = ~tx_pat;
            end else begin
                i_start  = 1'b0;
                i_pat_wr = 1'b0;
            end
            @(negedge i_clk);
        end
        i_stop = 1'b0;
        check($sformatf("%s frame_cnt_final", name), 32'(o_frame_cnt), 32'(exp_sent));
        check($sformatf("%s idle_busy", name), 32'(o_busy), 32'd0);
        check($sformatf("%s idle_done", name), 32'(o_done), 32'd0);
        check($sformatf("%s idle_out", name),  32'(o_out),  32'(IDLE_BIT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_frames = '0; i_pat_wr = 1'b0; i_pat_in = '0; i_stop = 1'b0;
        cur_pat = PATTERN;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("reset out",       32'(o_out),       32'(IDLE_BIT));
        check("reset valid",     32'(o_out_valid), 32'd0);
        check("reset busy",      32'(o_busy),      32'd0);
        check("reset done",      32'(o_done),      32'd0);
        check("reset frame_cnt", 32'(o_frame_cnt), 32'd0);

        run("single", '0, 1, 0, 1'b0, 1'b0);
        run("three", '0, 3, 0, 1'b0, 1'b0);
        run("patwr1100", 4'b1100, 2, 0, 1'b1, 1'b0);
        run("stop2nd", '0, 5, PAT_W + GAPS + 2, 1'b0, 1'b0);
        run("poke", '0, 3, 0, 1'b0, 1'b1);
        run("after_poke", '0, 1, 0, 1'b0, 1'b0);

        // Reset during the 3rd bit of frame 1 abandons the run without done.
        i_start = 1'b1; i_frames = 4'd3;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst third_bit", 32'(o_out), 32'(cur_pat[PAT_W-3]));
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        cur_pat = PATTERN;
        check("rst out",       32'(o_out),       32'(IDLE_BIT));
        check("rst busy",      32'(o_busy),      32'd0);
        check("rst valid",     32'(o_out_valid), 32'd0);
        check("rst done",      32'(o_done),      32'd0);
        check("rst frame_cnt", 32'(o_frame_cnt), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check($sformatf("rst quiet_done[%0d]", k), 32'(o_done), 32'd0);
            check($sformatf("rst quiet_busy[%0d]", k), 32'(o_busy), 32'd0);
        end

        // Start with zero frames is ignored.
        i_start = 1'b1; i_frames = '0;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("zero busy[%0d]", k),  32'(o_busy),      32'd0);
            check($sformatf("zero done[%0d]", k),  32'(o_done),      32'd0);
            check($sformatf("zero valid[%0d]", k), 32'(o_out_valid), 32'd0);
            @(negedge i_clk);
        end

        run("default_after_rst", '0, 2, 0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic [PAT_W-1:0] p;
            int f;
            int s;
            p = PAT_W'($urandom);
            f = int'($urandom_range(1, 4));
            s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, f * (PAT_W + GAPS))) : 0;
            run($sformatf("rand%0d", r), p, f, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
